// File: rtl/tpg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpg_pkg
// Description : Shared encodings for the four-phase timing-pulse generator:
//               FSM state codes, T1..T4 one-hot constants, last phase index.
// Revision    : 1.0 - initial release
// ============================================================================
package tpg_pkg;

  // Controller state codes
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;
  localparam logic [1:0] S_STEP     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = S_IDLE,
    ST_RUN      = S_RUN,
    ST_STOPPING = S_STOPPING,
    ST_STEP     = S_STEP
  } state_e;

  // One-hot phase outputs, bit0 = T1
  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;

  // Each T phase spans two ticks, so a full T1..T4 cycle ends at index 7
  localparam logic [2:0] PH_LAST = 3'd7;

  // Map the two upper phase-index bits onto the one-hot T output
  function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'd0:    oh = T1;
      2'd1:    oh = T2;
      2'd2:    oh = T3;
      default: oh = T4;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpg_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tpg_prescaler
// Description : Free-running divider producing a one-clock tick every
//               TICK_DIV clocks, with a synchronous clear back to count 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_prescaler #(
  parameter int TICK_DIV = 33554432
) (
  input  logic clk,
  input  logic i_clr,
  output logic o_tick
);

  localparam int          CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count 0..TICK_DIV-1 and wrap; a clear restarts the tick period
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/tpg_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tpg_sequencer_ctrl
// Description : Sequencer for the CP + T1..T4 timing-pulse generator.
//               Handles free-run, graceful stop at end of T4 and single-step
//               from one-cycle command pulses; level clear acts as reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_sequencer_ctrl
  import tpg_pkg::*;
#(
  parameter int TICK_DIV = 33554432,
  parameter int CNT_W    = 8
) (
  input  logic             sys_clk_in,
  input  logic             sys_rst_n,
  input  logic             clr_n,
  input  logic             start_req,
  input  logic             stop_req,
  input  logic             step_req,
  output logic             tick,
  output logic             cp,
  output logic [3:0]       t,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_e           r_state;
  logic [2:0]       r_ph;
  logic             r_cp;
  logic [3:0]       r_t;
  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_tick;
  logic             w_clr;
  logic             w_launch;
  logic             w_presc_clr;
  logic             w_adv;
  logic             w_eoc;
  state_e           w_state_nxt;
  logic [2:0]       w_ph_nxt;

  // Clear (reset or clr_n) dominates every command
  assign w_clr       = !sys_rst_n || !clr_n;
  // Launching a run or step realigns the prescaler so T1 gets full length
  assign w_launch    = (r_state == ST_IDLE) && (start_req || step_req);
  assign w_presc_clr = w_clr || w_launch;
  // Phase index advances on tick only while a cycle is in progress
  assign w_adv       = w_tick && (r_state != ST_IDLE);
  assign w_eoc       = w_adv && (r_ph == PH_LAST);

  tpg_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (sys_clk_in),
    .i_clr  (w_presc_clr),
    .o_tick (w_tick)
  );

  // Next state and phase index; commands are judged against the pre-tick state
  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = w_adv ? (r_ph + 3'd1) : r_ph;
    case (r_state)
      ST_IDLE: begin
        if (start_req) begin
          w_state_nxt = ST_RUN;
          w_ph_nxt    = 3'd0;
        end else if (step_req) begin
          w_state_nxt = ST_STEP;
          w_ph_nxt    = 3'd0;
        end
      end
      ST_RUN: begin
        if (stop_req) begin
          w_state_nxt = ST_STOPPING;
        end
      end
      ST_STOPPING, ST_STEP: begin
        if (start_req) begin
          w_state_nxt = ST_RUN;
        end else if (w_eoc) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ph_nxt    = 3'd0;
      end
    endcase
  end

  // FSM state plus registered outputs, derived from the next state/phase
  always_ff @(posedge sys_clk_in) begin
    if (w_clr) begin
      r_state <= ST_IDLE;
      r_ph    <= 3'd0;
      r_cp    <= 1'b0;
      r_t     <= 4'b0000;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
      if (w_tick) begin
        r_cp <= ~r_cp;
      end
      if (w_eoc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_t    <= (w_state_nxt != ST_IDLE) ? phase_onehot(w_ph_nxt[2:1]) : 4'b0000;
    end
  end

  assign tick      = w_tick;
  assign cp        = r_cp;
  assign t         = r_t;
  assign busy      = r_busy;
  assign cycle_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tpg_sequencer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpg_sequencer_ctrl
// Description : Self-checking bench for tpg_sequencer_ctrl (TICK_DIV=4,
//               CNT_W=2): directed scenarios plus randomized commands, all
//               compared against a clock-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpg_sequencer_ctrl;

  localparam int TD  = 4;
  localparam int CW  = 2;
  localparam int CYC = 8 * TD;   // clocks in one T1..T4 cycle

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;
  localparam int M_STEP = 3;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          clr_n     = 1'b1;
  logic          start_req = 1'b0;
  logic          stop_req  = 1'b0;
  logic          step_req  = 1'b0;
  logic          tick;
  logic          cp;
  logic [3:0]    t;
  logic          busy;
  logic [CW-1:0] cyc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, clock position within the cycle, prescaler, CP, count
  int m_mode = M_IDLE;
  int m_pos  = 0;
  int m_psc  = 0;
  int m_cnt  = 0;
  bit m_cp   = 1'b0;

  always #5 clk = ~clk;

  tpg_sequencer_ctrl #(
    .TICK_DIV (TD),
    .CNT_W    (CW)
  ) dut (
    .sys_clk_in (clk),
    .sys_rst_n  (rst_n),
    .clr_n      (clr_n),
    .start_req  (start_req),
    .stop_req   (stop_req),
    .step_req   (step_req),
    .tick       (tick),
    .cp         (cp),
    .t          (t),
    .busy       (busy),
    .cycle_cnt  (cyc)
  );

  function automatic logic [8:0] m_vec();
    logic [3:0] et;
    logic       eb;
    logic       etk;
    eb  = (m_mode != M_IDLE);
    et  = eb ? 4'(1 << (m_pos / (2 * TD))) : 4'b0000;
    etk = (m_psc == TD - 1);
    return {etk, m_cp, et, eb, 2'(m_cnt)};
  endfunction

  task automatic model_update();
    bit tk;
    bit eoc;
    int nm;
    if (!rst_n || !clr_n) begin
      m_mode = M_IDLE; m_pos = 0; m_psc = 0; m_cnt = 0; m_cp = 1'b0;
    end else begin
      tk = (m_psc == TD - 1);
      if (tk) m_cp = !m_cp;
      m_psc = (m_psc + 1) % TD;
      if (m_mode == M_IDLE) begin
        if (start_req) begin
          m_mode = M_RUN; m_pos = 0; m_psc = 0;
        end else if (step_req) begin
          m_mode = M_STEP; m_pos = 0; m_psc = 0;
        end
      end else begin
        eoc = (m_pos == CYC - 1);
        nm  = m_mode;
        if (m_mode == M_RUN) begin
          if (stop_req) nm = M_STOP;
        end else begin
          if (start_req) nm = M_RUN;
          else if (eoc)  nm = M_IDLE;
        end
        m_pos = (m_pos + 1) % CYC;
        if (eoc) m_cnt = (m_cnt + 1) % 4;
        m_mode = nm;
      end
    end
  endtask

  // Drive inputs on the falling edge, advance model on the rising edge, settle
  task automatic step_clk(input bit r, input bit c, input bit s, input bit p, input bit q);
    @(negedge clk);
    rst_n = r; clr_n = c; start_req = s; stop_req = p; step_req = q;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    step_clk(0, 1, 0, 0, 0);
    step_clk(0, 1, 1, 0, 0);
    n_checks++;
    if ({tick, cp, t, busy, cyc} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state actual=%b required=%b", {tick, cp, t, busy, cyc}, 9'b0);
    end
    step_clk(1, 1, 0, 0, 0);
    n_checks++;
    if ({tick, cp, t, busy, cyc} !== m_vec()) begin
      n_fail++;
      $display("FAIL reset_release actual=%b required=%b", {tick, cp, t, busy, cyc}, m_vec());
    end
  endtask

  task automatic test_run();
    step_clk(1, 1, 1, 0, 0);
    n_checks++;
    if (t !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start t=%b busy=%b required t=0001 busy=1", t, busy);
    end
    for (int k = 1; k <= 32; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL run_model k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
      if (k == 8 || k == 16 || k == 24) begin
        n_checks++;
        if (t !== 4'(1 << (k / 8))) begin
          n_fail++;
          $display("FAIL run_phase k=%0d t=%b required=%b", k, t, 4'(1 << (k / 8)));
        end
      end
      if (k == 32) begin
        n_checks++;
        if (t !== 4'b0001 || cyc !== 2'd1) begin
          n_fail++;
          $display("FAIL run_wrap t=%b cnt=%0d required t=0001 cnt=1", t, cyc);
        end
      end
    end
  endtask

  task automatic test_stop();
    int clocks;
    for (int k = 0; k < 10; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL stop_pre k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    step_clk(1, 1, 0, 1, 0);
    clocks = 0;
    while (busy === 1'b1 && clocks < 64) begin
      step_clk(1, 1, 0, 0, 0);
      clocks++;
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL stop_model k=%0d actual=%b required=%b", clocks, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    n_checks++;
    if (clocks != 21 || t !== 4'b0000 || busy !== 1'b0 || cyc !== 2'd2) begin
      n_fail++;
      $display("FAIL stop_end clocks=%0d t=%b busy=%b cnt=%0d required clocks=21 t=0000 busy=0 cnt=2",
               clocks, t, busy, cyc);
    end
    for (int k = 0; k < 10; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if (t !== 4'b0000 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_hold k=%0d t=%b busy=%b required t=0000 busy=0", k, t, busy);
      end
    end
  endtask

  task automatic test_step();
    int busy_clocks;
    step_clk(0, 1, 0, 0, 0);
    step_clk(1, 1, 0, 0, 0);
    step_clk(1, 1, 0, 0, 1);
    busy_clocks = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      step_clk(1, 1, 0, 0, (k == 10));
      if (busy === 1'b1) busy_clocks++;
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL step_model k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    n_checks++;
    if (busy_clocks != 32 || cyc !== 2'd1 || t !== 4'b0000) begin
      n_fail++;
      $display("FAIL step_len busy_clocks=%0d cnt=%0d t=%b required 32 cnt=1 t=0000", busy_clocks, cyc, t);
    end
  endtask

  task automatic test_priority();
    step_clk(1, 1, 1, 0, 0);
    for (int k = 0; k < 4; k++) step_clk(1, 1, 0, 0, 0);
    step_clk(1, 1, 1, 1, 0);
    for (int k = 0; k < 13; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL prio_stopping k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    step_clk(1, 1, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL prio_resume k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    n_checks++;
    if (busy !== 1'b1 || t !== 4'b0001 || cyc !== 2'd2) begin
      n_fail++;
      $display("FAIL prio_continue busy=%b t=%b cnt=%0d required busy=1 t=0001 cnt=2", busy, t, cyc);
    end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 10; k++) step_clk(1, 1, 0, 0, 0);
    n_checks++;
    if (t !== 4'b0100) begin
      n_fail++;
      $display("FAIL clr_pre t=%b required=0100", t);
    end
    step_clk(1, 0, 0, 0, 0);
    n_checks++;
    if ({tick, cp, t, busy, cyc} !== 9'b0) begin
      n_fail++;
      $display("FAIL clr_zero actual=%b required=%b", {tick, cp, t, busy, cyc}, 9'b0);
    end
    step_clk(1, 0, 1, 0, 0);
    step_clk(1, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || t !== 4'b0000) begin
      n_fail++;
      $display("FAIL clr_ignore busy=%b t=%b required busy=0 t=0000", busy, t);
    end
    step_clk(1, 1, 0, 0, 0);
    step_clk(1, 1, 1, 0, 0);
    n_checks++;
    if (t !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_restart t=%b busy=%b required t=0001 busy=1", t, busy);
    end
    for (int k = 1; k <= 8; k++) begin
      step_clk(1, 1, 0, 0, 0);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL clr_model k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
    n_checks++;
    if (t !== 4'b0010) begin
      n_fail++;
      $display("FAIL clr_t2 t=%b required=0010", t);
    end
  endtask

  task automatic test_wrap();
    step_clk(0, 1, 0, 0, 0);
    step_clk(1, 1, 0, 0, 0);
    step_clk(1, 1, 1, 0, 0);
    for (int k = 1; k <= 128; k++) begin
      step_clk(1, 1, 0, 0, 0);
      if (k % 32 == 0) begin
        n_checks++;
        if (cyc !== 2'((k / 32) % 4)) begin
          n_fail++;
          $display("FAIL wrap_cnt k=%0d cnt=%0d required=%0d", k, cyc, (k / 32) % 4);
        end
      end
    end
    for (int k = 0; k < 10; k++) step_clk(1, 1, 0, 0, 0);
    n_checks++;
    if (t !== 4'b0010) begin
      n_fail++;
      $display("FAIL wrap_t2 t=%b required=0010", t);
    end
    step_clk(0, 1, 0, 0, 0);
    n_checks++;
    if ({tick, cp, t, busy, cyc} !== 9'b0) begin
      n_fail++;
      $display("FAIL wrap_reset actual=%b required=%b", {tick, cp, t, busy, cyc}, 9'b0);
    end
    step_clk(1, 1, 0, 0, 0);
  endtask

  task automatic test_random();
    bit r, c, s, p, q;
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 299) != 0);
      c = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 29) == 0);
      q = ($urandom_range(0, 29) == 0);
      step_clk(r, c, s, p, q);
      n_checks++;
      if ({tick, cp, t, busy, cyc} !== m_vec()) begin
        n_fail++;
        $display("FAIL random k=%0d actual=%b required=%b", k, {tick, cp, t, busy, cyc}, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stop();
    test_step();
    test_priority();
    test_clear();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpg_sequencer_ctrl.md
Name: tpg_sequencer_ctrl

Overview:
Controller for the four-phase timing-pulse generator (CP plus T1..T4 one-hot phases).
- Takes debounced single-cycle command pulses (start, stop, single-step) and a level clear.
- Sequences the phase datapath through free-run, graceful-stop and one-cycle step modes.
- Sits between the button debounce front end and the LED/phase outputs on the EGO1 board.

Parameters:
TICK_DIV, 33554432, system clocks per tick (one CP half-period); must be >= 2
CNT_W, 8, width of the completed-cycle counter

Ports:
sys_clk_in  in   1      system clock; the only clock
sys_rst_n   in   1      reset, synchronous, active-low
clr_n       in   1      level clear (switch); low acts exactly like reset
start_req   in   1      one-cycle pulse: start free-run
stop_req    in   1      one-cycle pulse: graceful stop at end of current T4
step_req    in   1      one-cycle pulse: run exactly one T1..T4 cycle
tick        out  1      one-cycle strobe every TICK_DIV clocks
cp          out  1      CP indicator; toggles on every tick
t           out  4      one-hot phase, bit0=T1 .. bit3=T4; 0000 when idle
busy        out  1      high in any state other than IDLE
cycle_cnt   out  CNT_W  completed T1..T4 cycles; wraps modulo 2^CNT_W

Behaviour:
- All logic is synchronous to sys_clk_in. Reset, or clr_n low, forces on the next edge:
  - state = IDLE, prescaler = 0, ph = 0
  - tick = 0, cp = 0, t = 0000, busy = 0, cycle_cnt = 0
- While clr_n is low, all command pulses are ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1. tick = 1 for the one clock where count == TICK_DIV-1, then count wraps to 0.
  - Runs in every state.
  - Cleared to 0 on any IDLE->RUN or IDLE->STEP transition, so T1 lasts exactly 2*TICK_DIV clocks.
- cp toggles on every tick, in every state.
- Phase index ph[2:0]:
  - Increments on tick in RUN, STOPPING and STEP.
  - Each T phase spans two ticks: t = onehot(ph[2:1]) when state != IDLE, else 0000.
  - t, busy and cycle_cnt are registered. Latency from a command pulse to a t/busy change is 1 clock.
- End of cycle: tick with ph == 7.
  - ph wraps to 0 and cycle_cnt increments (wraps modulo 2^CNT_W).
  - RUN stays in RUN with t = 0001. STOPPING and STEP go to IDLE with t = 0000 and busy = 0.
- FSM states: IDLE, RUN, STOPPING, STEP.
  - IDLE:
    - start_req -> RUN, ph = 0.
    - Otherwise step_req -> STEP, ph = 0.
    - stop_req is ignored.
  - RUN:
    - stop_req -> STOPPING.
    - start_req and step_req are ignored.
  - STOPPING:
    - start_req -> RUN (stop cancelled; ph unchanged).
    - stop_req and step_req are ignored.
    - End of cycle -> IDLE.
  - STEP:
    - start_req -> RUN (ph unchanged).
    - stop_req and step_req are ignored.
    - End of cycle -> IDLE.
- Command priority:
  - Simultaneous start_req and stop_req in RUN: stop wins (-> STOPPING).
  - Simultaneous start_req and stop_req in STOPPING: start wins.
  - Simultaneous start_req and step_req in IDLE: start wins.
- If a command pulse coincides with an end-of-cycle tick, the command is evaluated against the pre-tick state. Example: stop_req in RUN on the ph==7 tick -> STOPPING with ph = 0, then a full further cycle runs.
- Reset or clr_n mid-operation aborts immediately. There is no graceful completion.

Decomposition:
- Shared package tpg_pkg holds:
  - state encoding localparams: S_IDLE, S_RUN, S_STOPPING, S_STEP (2 bits)
  - phase one-hot constants: T1 = 4'b0001 .. T4 = 4'b1000
  - PH_LAST = 3'd7
- Sub-module tpg_prescaler (tick generator) is parameterised by TICK_DIV.
  - Inputs: clk, synchronous clear (reset, clr_n low, or start of run).
  - Output: tick.

Test Plan (TICK_DIV=4, CNT_W=2):
1. Reset released, start_req pulse -> next clock t=0001, busy=1; t holds 8 clocks per phase: 0010 at +8, 0100 at +16, 1000 at +24; at +32 t=0001 and cycle_cnt=1.
2. RUN, stop_req during T2 -> T3 and T4 complete; at end of T4, t=0000, busy=0, cycle_cnt incremented by 1; t stays 0000 afterwards.
3. IDLE, step_req -> exactly 32 clocks of T1..T4, then IDLE, cycle_cnt=1; a second step_req during the step is ignored (no extra cycle).
4. RUN, start_req and stop_req in the same clock -> STOPPING; start_req in T3 -> RUN; phases continue past T4 into T1 with busy=1.
5. clr_n low mid-T3 -> next clock t=0000, busy=0, cp=0, cycle_cnt=0; start_req while clr_n is low is ignored; after clr_n rises, start_req works as in scenario 1.
6. Free-run 4 full cycles -> cycle_cnt goes 1,2,3,0 (wrap); sys_rst_n low mid-T2 -> all outputs zero on the next edge.
